// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the FPU datapath stages.
package fpu_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int PROD_W   = 2 * (MAN_W + 1);
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Normalized product carried from stage 1 to stage 2.
    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W+1:0] e;
        logic [MAN_W-1:0]        m;
        logic                    g;
        logic                    s;
        logic                    nan;
        logic                    invalid;
        logic                    inf;
        logic                    zero;
    } s1_payload_t;
endpackage

// File: rtl/fpu_rne_round.sv
// Round-to-nearest-even and pack of a normalized finite value, flushing to zero.
module fpu_rne_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    sign,
    input  logic [MAN_W-1:0]        m,
    input  logic                    g,
    input  logic                    s,
    input  logic signed [EXP_W+1:0] e,
    output logic [EXP_W+MAN_W:0]    result,
    output fp_flags_t               flags
);
    localparam int EMAX = (1 << EXP_W) - 1;

    logic                    up;
    logic [MAN_W:0]          m_sum;
    logic signed [EXP_W+2:0] e_rnd;

    always_comb begin
        up     = g & (s | m[0]);
        m_sum  = {1'b0, m} + {{MAN_W{1'b0}}, up};
        // A carry out of the fraction leaves its low bits zero, so only the exponent moves.
        e_rnd  = (EXP_W+3)'(e) + {{(EXP_W+2){1'b0}}, m_sum[MAN_W]};
        result = '0;
        flags  = '0;
        if (e <= 0) begin
            result          = {sign, {(EXP_W+MAN_W){1'b0}}};
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
        end else if (e_rnd >= EMAX) begin
            result         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
        end else begin
            result        = {sign, e_rnd[EXP_W-1:0], m_sum[MAN_W-1:0]};
            flags.inexact = g | s;
        end
    end
endmodule

// File: rtl/fpu_mul_round.sv
// Two-stage normalize/round back end of the binary32 multiplier with valid/ready on both sides.
module fpu_mul_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W+1:0]          in_exp,
    input  logic [2*(MAN_W+1)-1:0]    in_mant,
    input  logic                      in_nan,
    input  logic                      in_invalid,
    input  logic                      in_inf,
    input  logic                      in_zero,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MAN_W:0]      out_result,
    output logic [3:0]                out_flags
);
    localparam int PW = 2 * (MAN_W + 1);

    logic [2:1]               vld_pipe;
    logic                     s1_adv, s2_adv;
    s1_payload_t              nrm, s1_q;
    logic [EXP_W+MAN_W:0]     rnd_result, res_d;
    fp_flags_t                rnd_flags, flg_d;

    assign s2_adv    = !vld_pipe[2] | out_ready;
    assign s1_adv    = !vld_pipe[1] | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];

    // The product of two hidden-bit significands is in [1,4): one bit of normalization at most.
    always_comb begin
        nrm         = '0;
        nrm.sign    = in_sign;
        nrm.nan     = in_nan;
        nrm.invalid = in_invalid;
        nrm.inf     = in_inf;
        nrm.zero    = in_zero;
        if (in_mant[PW-1]) begin
            nrm.m = in_mant[PW-2 -: MAN_W];
            nrm.g = in_mant[PW-2-MAN_W];
            nrm.s = |in_mant[PW-3-MAN_W:0];
            nrm.e = in_exp + (EXP_W+2)'(1);
        end else begin
            nrm.m = in_mant[PW-3 -: MAN_W];
            nrm.g = in_mant[PW-3-MAN_W];
            nrm.s = |in_mant[PW-4-MAN_W:0];
            nrm.e = in_exp;
        end
    end

    fpu_rne_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign   (s1_q.sign),
        .m      (s1_q.m),
        .g      (s1_q.g),
        .s      (s1_q.s),
        .e      (s1_q.e),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

    always_comb begin
        res_d = rnd_result;
        flg_d = rnd_flags;
        if (s1_q.nan) begin
            res_d         = QNAN;
            flg_d         = '0;
            flg_d.invalid = s1_q.invalid;
        end else if (s1_q.inf) begin
            res_d = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_d = '0;
        end else if (s1_q.zero) begin
            res_d = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
            flg_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1_q       <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= nrm;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_result <= res_d;
                    out_flags  <= flg_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_mul_round.sv
// Self-checking bench for fpu_mul_round: directed corner cases, backpressure, reset and random traffic.
module tb_fpu_mul_round;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_sign, in_nan, in_invalid, in_inf, in_zero;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    always #5 clk = ~clk;

    fpu_mul_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .in_nan(in_nan),
        .in_invalid(in_invalid), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        nan, inv, inf, zero;
        logic [31:0] res;
        logic [3:0]  flg;
    } item_t;

    item_t pend[$];
    item_t sb[$];
    int    acc_cyc[$];
    int    compared = 0, mismatched = 0;
    int    cyc = 0, n_in = 0, n_out = 0, last_lat = 0;
    logic  gate_in = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact integer rounding on the remainder below the kept 24 significant bits.
    function automatic item_t model(item_t it);
        item_t       r = it;
        logic [63:0] mant, keep, rem, half;
        int          e, sh;
        bit          inexact;
        mant = {16'b0, it.mant};
        e    = int'($signed(it.exp));
        if (it.nan) begin
            r.res = 32'h7FC0_0000; r.flg = {it.inv, 3'b000};
        end else if (it.inf) begin
            r.res = {it.sign, 8'hFF, 23'd0}; r.flg = 4'b0000;
        end else if (it.zero) begin
            r.res = {it.sign, 31'd0}; r.flg = 4'b0000;
        end else begin
            sh = mant[47] ? 24 : 23;
            if (mant[47]) e++;
            keep    = mant >> sh;
            rem     = mant - (keep << sh);
            half    = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            if (e <= 0) begin
                r.res = {it.sign, 31'd0}; r.flg = 4'b0011;
            end else begin
                if (rem > half || (rem == half && keep[0])) keep = keep + 1;
                if (keep == (64'd1 << 24)) begin keep = keep >> 1; e++; end
                if (e >= 255) begin
                    r.res = {it.sign, 8'hFF, 23'd0}; r.flg = 4'b0101;
                end else begin
                    r.res = {it.sign, 8'(e), keep[22:0]}; r.flg = {3'b000, inexact};
                end
            end
        end
        return r;
    endfunction

    task automatic push_dir(logic sg, logic [9:0] ex, logic [47:0] mn, logic nn, logic iv,
                            logic nf, logic zr, logic [31:0] r, logic [3:0] f);
        item_t it;
        it.sign = sg; it.exp = ex; it.mant = mn; it.nan = nn; it.inv = iv;
        it.inf = nf; it.zero = zr; it.res = r; it.flg = f;
        pend.push_back(it);
    endtask

    task automatic push_rand();
        item_t       it;
        logic [23:0] a, b;
        int          v, sel;
        a = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        b = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        it.mant = {24'd0, a} * {24'd0, b};
        if ($urandom_range(0, 3) == 0) it.mant[21:0] = 22'd0;
        v = $urandom_range(0, 330) - 20;
        it.exp  = v[9:0];
        it.sign = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 11);
        it.nan  = (sel == 0);
        it.inv  = (sel == 0) && ($urandom_range(0, 1) == 1);
        it.inf  = (sel == 1);
        it.zero = (sel == 2);
        it.res = '0; it.flg = '0;
        pend.push_back(model(it));
    endtask

    task automatic cycle();
        bit    acc_in, acc_out;
        item_t e;
        in_valid = gate_in && (pend.size() > 0);
        if (pend.size() > 0) begin
            in_sign = pend[0].sign; in_exp = pend[0].exp; in_mant = pend[0].mant;
            in_nan = pend[0].nan; in_invalid = pend[0].inv; in_inf = pend[0].inf; in_zero = pend[0].zero;
        end
        #1;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        if (acc_out) begin
            if (sb.size() == 0) check("spurious_output", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("result", out_result, e.res);
                check("flags", 32'(out_flags), 32'(e.flg));
                last_lat = cyc - acc_cyc.pop_front();
                n_out++;
            end
        end
        if (acc_in) begin
            sb.push_back(pend.pop_front());
            acc_cyc.push_back(cyc);
            n_in++;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          k, base, pushed;
        logic [31:0] hold;
        in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0;
        in_nan = 0; in_invalid = 0; in_inf = 0; in_zero = 0; out_ready = 1;
        #22;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        push_dir(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 0, 32'h4010_0000, 4'b0000);
        gate_in = 1;
        k = 0;
        while (n_out < 1 && k < 20) begin cycle(); k++; end
        check("first_done", 32'(n_out), 32'd1);
        check("latency", 32'(last_lat), 32'd2);

        push_dir(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 0, 32'h3F80_0002, 4'b0001);
        push_dir(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 0, 32'h3F80_0000, 4'b0001);
        push_dir(0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, 0, 32'h4000_0000, 4'b0001);
        push_dir(0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 0, 32'h7F80_0000, 4'b0101);
        push_dir(1, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 0, 32'h8000_0000, 4'b0011);
        push_dir(0, 10'd0,   48'h8000_0000_0000, 0, 0, 0, 0, 32'h0080_0000, 4'b0000);
        push_dir(0, 10'd5,   48'h0,              1, 1, 0, 0, 32'h7FC0_0000, 4'b1000);
        push_dir(1, 10'd5,   48'h0,              0, 0, 1, 0, 32'hFF80_0000, 4'b0000);
        push_dir(1, 10'd5,   48'h0,              0, 0, 0, 1, 32'h8000_0000, 4'b0000);
        k = 0;
        while (n_out < 10 && k < 60) begin cycle(); k++; end
        check("directed_done", 32'(n_out), 32'd10);

        out_ready = 0;
        repeat (4) push_rand();
        base = n_in;
        repeat (6) cycle();
        check("bp_accepts", 32'(n_in - base), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        hold = out_result;
        repeat (3) cycle();
        check("bp_stable", out_result, hold);
        out_ready = 1;
        base = n_out;
        k = 0;
        while (n_out - base < 4 && k < 20) begin cycle(); k++; end
        check("drain_cycles", 32'(k), 32'd4);

        out_ready = 0;
        repeat (2) push_rand();
        repeat (4) cycle();
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_result", out_result, 32'd0);
        pend.delete(); sb.delete(); acc_cyc.delete();
        gate_in = 0; in_valid = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        out_ready = 1;
        @(posedge clk); #1;
        repeat (5) begin
            cycle();
            check("post_rst_no_out", 32'(out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        base = n_out; pushed = 0; k = 0;
        while (pushed < 300 && k < 5000) begin
            if (pend.size() < 3) begin push_rand(); pushed++; end
            gate_in   = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            k++;
        end
        gate_in = 1; out_ready = 1;
        k = 0;
        while ((pend.size() > 0 || sb.size() > 0) && k < 200) begin cycle(); k++; end
        check("random_count", 32'(n_out - base), 32'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
